// File: rtl/backend_seq_pkg.sv
// backend_seq_pkg: state encoding, arbiter routing modes and default latencies for backend_sequencer.
// The POOL state exists only when BACKEND_SEQ_AVG_POOL_EN is defined.
package backend_seq_pkg;
    localparam int DEF_ADDER_LAT = 2;
    localparam int DEF_ARB_LAT = 1;
    localparam logic [3:0] ARB_MODE_IDLE = 4'd0;
    localparam logic [3:0] ARB_MODE_ROW = 4'd1;
    localparam logic [3:0] ARB_MODE_COL = 4'd2;
    localparam logic [3:0] ARB_MODE_BCAST = 4'd3;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
`ifdef BACKEND_SEQ_AVG_POOL_EN
        POOL = 3'd4,
`endif
        WRITEBACK = 3'd5,
        DONE = 3'd6
    } state_t;
endpackage

// File: rtl/backend_sequencer_valid_delay_line.sv
// valid_delay_line: fixed-depth shift register that flushes to zero on reset.
// occupied reports whether any stage still holds a nonzero entry.
module valid_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] delayed,
    output logic             occupied
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= data;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign delayed = pipe[DEPTH-1];
    assign occupied = |pipe;
endmodule

// File: rtl/backend_sequencer.sv
// backend_sequencer: tile-level control of the adder tree, arbiter, accumulator and DDR writeback.
// Define BACKEND_SEQ_AVG_POOL_EN to add cfg_pool, pool_enable and the POOL state.
module backend_sequencer
    import backend_seq_pkg::*;
#(
    parameter int ADDER_LAT = DEF_ADDER_LAT,
    parameter int ARB_LAT = DEF_ARB_LAT,
    parameter int GROUP_W = 8,
    parameter int BEAT_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        cfg_mode,
    input  logic [GROUP_W-1:0] cfg_groups,
    input  logic [BEAT_W-1:0] cfg_wb_beats,
`ifdef BACKEND_SEQ_AVG_POOL_EN
    input  logic              cfg_pool,
    output logic              pool_enable,
`endif
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              ddr_ready,
    output logic              adder_enable,
    output logic [3:0]        arbiter_ctrl,
    output logic              accumulator_reset,
    output logic              accumulator_enable,
    output logic              accum_data_select,
    output logic              bram_wr_en,
    output logic              ddr_valid,
    output logic [BEAT_W-1:0] ddr_beat,
    output logic              busy,
    output logic              done
);
    localparam int PIPE_LAT = ADDER_LAT + ARB_LAT;

    state_t state, next, wb_or_done, after_drain;
    logic [3:0] mode;
    logic [GROUP_W-1:0] last_group, group_cnt;
    logic [BEAT_W-1:0] wb_beats, last_beat, beat_cnt;
    logic launch, accept, pipe_busy, acc_valid, acc_first, drained;

    assign launch = state == IDLE && start;
    assign accept = state == ACCUM && prod_valid;
    assign last_beat = wb_beats - BEAT_W'(1);
    assign drained = !pipe_busy && !bram_wr_en;
    assign wb_or_done = wb_beats == '0 ? DONE : WRITEBACK;

`ifdef BACKEND_SEQ_AVG_POOL_EN
    logic pool;
    assign after_drain = pool ? POOL : wb_or_done;
    assign pool_enable = state == POOL;
`else
    assign after_drain = wb_or_done;
`endif

    // carries {valid, first_group} so the accumulator sees them aligned with arbiter output
    valid_delay_line #(.DEPTH(PIPE_LAT), .WIDTH(2)) u_pipe (
        .clock(clock),
        .reset(reset),
        .data({accept, accept && group_cnt == '0}),
        .delayed({acc_valid, acc_first}),
        .occupied(pipe_busy)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:      next = start ? CLEAR : IDLE;
            CLEAR:     next = ACCUM;
            ACCUM:     next = (accept && group_cnt == last_group) ? DRAIN : ACCUM;
            DRAIN:     next = drained ? after_drain : DRAIN;
`ifdef BACKEND_SEQ_AVG_POOL_EN
            POOL:      next = wb_or_done;
`endif
            WRITEBACK: next = (ddr_ready && beat_cnt == last_beat) ? DONE : WRITEBACK;
            DONE:      next = IDLE;
            default:   next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy <= 1'b0;
            bram_wr_en <= 1'b0;
            mode <= ARB_MODE_IDLE;
            last_group <= '0;
            wb_beats <= '0;
            group_cnt <= '0;
            beat_cnt <= '0;
`ifdef BACKEND_SEQ_AVG_POOL_EN
            pool <= 1'b0;
`endif
        end else begin
            state <= next;
            busy <= next != IDLE;
            bram_wr_en <= acc_valid;
            if (launch) begin
                mode <= cfg_mode;
                last_group <= cfg_groups == '0 ? '0 : cfg_groups - GROUP_W'(1);
                wb_beats <= cfg_wb_beats;
                group_cnt <= '0;
`ifdef BACKEND_SEQ_AVG_POOL_EN
                pool <= cfg_pool;
`endif
            end else if (accept && group_cnt != last_group) begin
                group_cnt <= group_cnt + GROUP_W'(1);
            end
            if (launch || (next == WRITEBACK && state != WRITEBACK))
                beat_cnt <= '0;
            else if (ddr_valid && ddr_ready && beat_cnt != last_beat)
                beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    assign prod_ready = state == ACCUM;
    assign adder_enable = accept;
    assign accumulator_reset = state == CLEAR;
    assign accumulator_enable = acc_valid;
    assign accum_data_select = acc_valid && !acc_first;
    assign arbiter_ctrl = busy ? mode : ARB_MODE_IDLE;
    assign ddr_valid = state == WRITEBACK;
    assign ddr_beat = ddr_valid ? beat_cnt : '0;
    assign done = state == DONE;
endmodule

// File: doc/backend_sequencer.md
# backend_sequencer

Control sequencer for the convolution backend (adder tree → address RF → backend arbiter → accumulator → DDR). It accepts a tile command, accepts product beats from the multiplier array under a valid/ready handshake, and drives the adder-tree enable, arbiter routing control and accumulator controls. Enables are time-aligned to the backend pipeline latency. It then drains the pipeline, runs a DDR writeback handshake and pulses `done`. It sits beside the backend datapath in the top-level controller.

## Interface
- `ADDER_LAT`, 2: adder-tree latency in cycles, ≥1
- `ARB_LAT`, 1: address RF plus arbiter latency in cycles, ≥1
- `GROUP_W`, 8: width of the group counter
- `BEAT_W`, 12: width of the writeback beat counter
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: tile command strobe; sampled only in IDLE
- `cfg_mode` in 4: arbiter routing mode; latched on accepted `start`
- `cfg_groups` in GROUP_W: product beats per tile; latched; 0 is treated as 1
- `cfg_wb_beats` in BEAT_W: DDR beats per tile; latched; 0 skips writeback
- `prod_valid` in 1: multiplier products valid
- `prod_ready` out 1: sequencer accepts a product beat
- `ddr_ready` in 1: DDR sink accepts the current beat
- `adder_enable` out 1: adder tree consumes products this cycle
- `arbiter_ctrl` out 4: latched `cfg_mode`; 0 outside a tile
- `accumulator_reset` out 1: clears the accumulator
- `accumulator_enable` out 1: accumulator captures arbiter output
- `accum_data_select` out 1: 0 = first group (ignore BRAM), 1 = add BRAM partial sum
- `bram_wr_en` out 1: write accumulator result to BRAM
- `ddr_valid` out 1: DDR beat valid
- `ddr_beat` out BEAT_W: index of the current writeback beat
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, (POOL), WRITEBACK, DONE.
- IDLE + `start`: latch the config and go to CLEAR.
- CLEAR: `accumulator_reset`=1 for exactly one cycle, then go to ACCUM.
- ACCUM: `prod_ready`=1. A beat is accepted on `prod_valid & prod_ready`.
  - `adder_enable` equals the acceptance, combinationally in the same cycle.
  - The group counter increments on each acceptance.
  - The last accepted beat (count = `cfg_groups`−1) moves the FSM to DRAIN.
- PIPE_LAT = ADDER_LAT + ARB_LAT. A valid delay line of depth PIPE_LAT carries {valid, first_flag}.
  - `accumulator_enable` = delay-line valid output.
  - `accum_data_select` = !first_flag, where first_flag marks group 0.
- `bram_wr_en` = `accumulator_enable` delayed one cycle.
- DRAIN: wait until the delay line and the `bram_wr_en` stage are both empty.
  - Then go to WRITEBACK, or to DONE if `cfg_wb_beats`=0.
- WRITEBACK: `ddr_valid`=1 with `ddr_beat`=k.
  - k increments on `ddr_valid & ddr_ready`.
  - The beat k=`cfg_wb_beats`−1 completes the phase and the FSM goes to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Outside ACCUM, `prod_ready`=0 and `prod_valid` is ignored.
- `start` while busy is ignored; no queuing.
- Counters never wrap; they are cleared on entry to CLEAR and WRITEBACK.

## Timing
- Reset (asynchronous assert):
  - State = IDLE; delay line and counters flushed.
  - Every output is 0, including `arbiter_ctrl` and `ddr_beat`.
- Reset deassertion is synchronised externally. Reset mid-tile abandons the tile without a `done` pulse.
- `start` in cycle 0: CLEAR in cycle 1, first possible acceptance in cycle 2.
- A beat accepted in cycle c produces `accumulator_enable` in c+PIPE_LAT and `bram_wr_en` in c+PIPE_LAT+1.
- Back-to-back acceptances give back-to-back enables; bubbles in `prod_valid` are preserved exactly.
- `ddr_valid` and `ddr_beat` stay stable while `ddr_ready`=0.
- `done` is asserted in the cycle after the final DDR handshake, or the cycle after DRAIN ends when writeback is skipped.
- `start` in the DONE cycle is ignored.
- `busy` is registered from the state.

## Configuration
- `BACKEND_SEQ_AVG_POOL_EN` defined:
  - Adds input `cfg_pool` (1 bit, latched at start), output `pool_enable` (reset 0) and state POOL between DRAIN and WRITEBACK.
  - If `cfg_pool`=1, POOL asserts `pool_enable` for exactly one cycle.
  - If `cfg_pool`=0, POOL is skipped.
- Undefined: the ports and the POOL state are absent; DRAIN goes directly to WRITEBACK or DONE.

## Structure
- Package `backend_seq_pkg`:
  - State enum.
  - `arbiter_ctrl` mode encodings.
  - Default latency constants.
- Sub-module `valid_delay_line`: parameterised depth and width, async active-low reset, flush to 0; instantiated for the {valid, first_flag} pipe.

## Test plan
- Groups=1, wb=2, `prod_valid` high from cycle 2, `ddr_ready`=1:
  - `accumulator_reset` at cycle 1; `adder_enable` at 2.
  - `accumulator_enable`/select=0 at 5; `bram_wr_en` at 6.
  - `ddr_beat` 0,1 handshaked; `done` once.
- Groups=4 with `prod_valid` 1,0,1,1,1:
  - Exactly 4 `accumulator_enable` pulses with the same bubble pattern, shifted by 3 cycles.
  - Select 0,1,1,1.
- wb=3 with `ddr_ready` toggling 0,1,0,0,1,1:
  - `ddr_beat` held stable while stalled; beats 0,1,2 each transferred exactly once.
- Groups=0 and wb=0: treated as one group; writeback skipped; `done` right after drain.
- Reset asserted mid-ACCUM:
  - All outputs 0 immediately, no `done`.
  - A new `start` runs cleanly.
- `start` pulsed during ACCUM and during the DONE cycle: ignored, no second tile. With the macro defined and `cfg_pool`=1: a single `pool_enable` between drain and the first `ddr_valid`.
